kernel_bank: RTL and testbench

- Parametrised multi-neuron kernel weight store for the convolution datapath.
- Loads one ROWS×COLS kernel per neuron, one row per handshake beat. Also supports a broadcast load into every neuron.
- Tracks which neurons hold a complete kernel and presents all kernels in parallel to the MAC array.

---
 rtl/kernel_bank_pkg.sv | 32 +++
 rtl/kernel_bank_ctrl.sv | 163 ++++++++++++++++
 rtl/kernel_bank.sv | 112 +++++++++++
 tb/tb_kernel_bank.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/kernel_bank_pkg.sv
// -----------------------------------------------------------------------------
// kernel_bank_pkg
// Shared definitions for the kernel weight store and the MAC array that reads it:
//   - default geometry constants (neuron slots, kernel rows/cols, element width)
//   - load controller state encoding
//   - clog2_min1: index width helper that never returns zero
// -----------------------------------------------------------------------------
package kernel_bank_pkg;

  localparam int DEF_NEURONS = 4;
  localparam int DEF_ROWS    = 4;
  localparam int DEF_COLS    = 4;
  localparam int DEF_WIDTH   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of an index into n items; a single item still needs one bit.
  function automatic int clog2_min1(input int n);
    int w;
    if (n > 1) begin
      w = $clog2(n);
    end else begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/kernel_bank_ctrl.sv
// -----------------------------------------------------------------------------
// kernel_bank_ctrl
// Load sequencer for kernel_bank: FSM (IDLE/LOAD/DONE), row counter, handshake,
// done/err pulses, and the per-slot write/flag masks used by the storage.
// Ports:
//   clock, reset         rising-edge clock, asynchronous active-high reset
//   start, neuron_sel,   load request with its target slot / broadcast flag
//   bcast
//   clear                abort any load, return to IDLE (highest priority)
//   in_valid, in_ready   row beat handshake
//   busy, done, err      status: not idle / load complete / bad slot request
//   row_we, row_idx      per-slot row write enable and row being written
//   start_mask           slots whose loaded flag drops as a load begins
//   fill_mask            slots whose loaded flag rises as a load completes
// -----------------------------------------------------------------------------
module kernel_bank_ctrl
  import kernel_bank_pkg::*;
#(
  parameter int NEURONS = DEF_NEURONS,
  parameter int ROWS    = DEF_ROWS
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                start,
  input  logic [clog2_min1(NEURONS)-1:0]      neuron_sel,
  input  logic                                bcast,
  input  logic                                clear,
  input  logic                                in_valid,
  output logic                                in_ready,
  output logic                                busy,
  output logic                                done,
  output logic                                err,
  output logic [NEURONS-1:0]                  row_we,
  output logic [clog2_min1(ROWS)-1:0]         row_idx,
  output logic [NEURONS-1:0]                  start_mask,
  output logic [NEURONS-1:0]                  fill_mask
);

  localparam int              SEL_W     = clog2_min1(NEURONS);
  localparam int              RC_W      = clog2_min1(ROWS);
  localparam logic [RC_W-1:0] LAST_ROW  = RC_W'(ROWS - 1);
  localparam logic [31:0]     NEURONS_U = 32'(NEURONS);

  state_t            state_q, state_d;
  logic [RC_W-1:0]   row_cnt_q, row_cnt_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              bcast_q, bcast_d;
  logic              err_q, err_d;

  logic              sel_in_range;
  logic              start_ok;
  logic              start_bad;
  logic              beat;
  logic              last_beat;
  logic [NEURONS-1:0] latched_mask;
  logic [NEURONS-1:0] request_mask;

  // Qualify the start request and the current row beat; clear masks both.
  always_comb begin
    // neuron_sel may be wide enough to name non-existent slots (e.g. 3 of 3).
    sel_in_range = (32'(neuron_sel) < NEURONS_U);
    start_ok     = (state_q == IDLE) && start && !clear && (bcast || sel_in_range);
    start_bad    = (state_q == IDLE) && start && !clear && !bcast && !sel_in_range;
    beat         = (state_q == LOAD) && in_valid && !clear;
    last_beat    = beat && (row_cnt_q == LAST_ROW);
  end

  // Slot masks: the live request (invalidated at start) and the latched target.
  always_comb begin
    latched_mask = {NEURONS{1'b0}};
    request_mask = {NEURONS{1'b0}};
    for (int n = 0; n < NEURONS; n++) begin
      latched_mask[n] = bcast_q || (sel_q == SEL_W'(n));
      request_mask[n] = bcast || (neuron_sel == SEL_W'(n));
    end
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; clear overrides every other input.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_ok) begin
            state_d = LOAD;
          end else begin
            state_d = IDLE;
          end
        end
        LOAD: begin
          if (last_beat) begin
            state_d = DONE;
          end else begin
            state_d = LOAD;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Row counter, latched target and error pulse next values.
  always_comb begin
    row_cnt_d = row_cnt_q;
    sel_d     = sel_q;
    bcast_d   = bcast_q;
    err_d     = start_bad;
    if (clear) begin
      row_cnt_d = {RC_W{1'b0}};
    end else if (start_ok) begin
      row_cnt_d = {RC_W{1'b0}};
      sel_d     = neuron_sel;
      bcast_d   = bcast;
    end else if (last_beat) begin
      // Explicit wrap so non-power-of-two ROWS never walk past the last row.
      row_cnt_d = {RC_W{1'b0}};
    end else if (beat) begin
      row_cnt_d = row_cnt_q + RC_W'(1);
    end else begin
      row_cnt_d = row_cnt_q;
    end
  end

  // Row counter, latched target and error pulse registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      row_cnt_q <= {RC_W{1'b0}};
      sel_q     <= {SEL_W{1'b0}};
      bcast_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      row_cnt_q <= row_cnt_d;
      sel_q     <= sel_d;
      bcast_q   <= bcast_d;
      err_q     <= err_d;
    end
  end

  // Outputs decoded from registered state; write masks gated by the beat.
  always_comb begin
    in_ready   = (state_q == LOAD);
    busy       = (state_q != IDLE);
    done       = (state_q == DONE);
    err        = err_q;
    row_idx    = row_cnt_q;
    row_we     = beat      ? latched_mask : {NEURONS{1'b0}};
    fill_mask  = last_beat ? latched_mask : {NEURONS{1'b0}};
    start_mask = start_ok  ? request_mask : {NEURONS{1'b0}};
  end

endmodule

// File: rtl/kernel_bank.sv
// -----------------------------------------------------------------------------
// kernel_bank
// Multi-neuron kernel weight store. Each slot holds a ROWS x COLS kernel of
// WIDTH-bit elements, loaded one row per handshake beat (or broadcast to all
// slots). All kernels are presented in parallel to the MAC array.
// Ports:
//   clock, reset         rising-edge clock, asynchronous active-high reset
//   start                begin a load (accepted only while idle)
//   neuron_sel, bcast    target slot / write-all flag, sampled with start
//   clear                drop all loaded flags and abort any load
//   in_valid, in_ready,  row beat handshake; element c of the row at in_row[c]
//   in_row
//   busy, done, err      not idle / one-cycle completion / one-cycle bad request
//   loaded               per-slot "complete kernel present" flags
//   kernels              registered kernel contents [slot][row][col]
// -----------------------------------------------------------------------------
module kernel_bank
  import kernel_bank_pkg::*;
#(
  parameter int NEURONS = DEF_NEURONS,
  parameter int ROWS    = DEF_ROWS,
  parameter int COLS    = DEF_COLS,
  parameter int WIDTH   = DEF_WIDTH
) (
  input  logic                                          clock,
  input  logic                                          reset,
  input  logic                                          start,
  input  logic [clog2_min1(NEURONS)-1:0]                neuron_sel,
  input  logic                                          bcast,
  input  logic                                          clear,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic [COLS-1:0][WIDTH-1:0]                    in_row,
  output logic                                          busy,
  output logic                                          done,
  output logic                                          err,
  output logic [NEURONS-1:0]                            loaded,
  output logic [NEURONS-1:0][ROWS-1:0][COLS-1:0][WIDTH-1:0] kernels
);

  localparam int RC_W  = clog2_min1(ROWS);
  localparam int KBITS = NEURONS * ROWS * COLS * WIDTH;

  logic [NEURONS-1:0] row_we;
  logic [NEURONS-1:0] start_mask;
  logic [NEURONS-1:0] fill_mask;
  logic [RC_W-1:0]    row_idx;

  logic [NEURONS-1:0] loaded_q, loaded_d;
  logic [NEURONS-1:0][ROWS-1:0][COLS-1:0][WIDTH-1:0] kernels_q, kernels_d;

  kernel_bank_ctrl #(
    .NEURONS (NEURONS),
    .ROWS    (ROWS)
  ) u_ctrl (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .neuron_sel (neuron_sel),
    .bcast      (bcast),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .row_we     (row_we),
    .row_idx    (row_idx),
    .start_mask (start_mask),
    .fill_mask  (fill_mask)
  );

  // Row write into every enabled slot; rows not addressed keep their contents.
  always_comb begin
    kernels_d = kernels_q;
    for (int n = 0; n < NEURONS; n++) begin
      for (int r = 0; r < ROWS; r++) begin
        if (row_we[n] && (row_idx == RC_W'(r))) begin
          kernels_d[n][r] = in_row;
        end else begin
          kernels_d[n][r] = kernels_q[n][r];
        end
      end
    end
  end

  // Loaded flags: drop on load start, rise on completion; clear wipes all.
  // Rows written by an aborted load are deliberately not rolled back.
  always_comb begin
    loaded_d = loaded_q;
    if (clear) begin
      loaded_d = {NEURONS{1'b0}};
    end else begin
      loaded_d = (loaded_q & ~start_mask) | fill_mask;
    end
  end

  // Storage and flag registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      kernels_q <= {KBITS{1'b0}};
      loaded_q  <= {NEURONS{1'b0}};
    end else begin
      kernels_q <= kernels_d;
      loaded_q  <= loaded_d;
    end
  end

  assign loaded  = loaded_q;
  assign kernels = kernels_q;

endmodule

// File: tb/tb_kernel_bank.sv
// Directed testbench for kernel_bank: a default-geometry instance (4x4x4x8)
// and a small odd-geometry instance (3 slots, 3 rows, 5 cols, 12-bit).
module tb_kernel_bank;
  import kernel_bank_pkg::*;

  typedef logic [3:0][7:0]              row0_t;
  typedef logic [3:0][3:0][3:0][7:0]    kern0_t;
  typedef logic [4:0][11:0]             row1_t;
  typedef logic [2:0][2:0][4:0][11:0]   kern1_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  // default instance
  logic start0, bcast0, clear0, valid0, ready0, busy0, done0, err0;
  logic [1:0] sel0;
  row0_t      row0;
  logic [3:0] loaded0;
  kern0_t     kern0;

  // odd-geometry instance
  logic start1, bcast1, clear1, valid1, ready1, busy1, done1, err1;
  logic [1:0] sel1;
  row1_t      row1;
  logic [2:0] loaded1;
  kern1_t     kern1;

  int checks = 0;
  int errors = 0;
  kern0_t exp0;
  kern1_t exp1;

  kernel_bank #(.NEURONS(4), .ROWS(4), .COLS(4), .WIDTH(8)) dut0 (
    .clock(clock), .reset(reset), .start(start0), .neuron_sel(sel0), .bcast(bcast0),
    .clear(clear0), .in_valid(valid0), .in_ready(ready0), .in_row(row0), .busy(busy0),
    .done(done0), .err(err0), .loaded(loaded0), .kernels(kern0)
  );

  kernel_bank #(.NEURONS(3), .ROWS(3), .COLS(5), .WIDTH(12)) dut1 (
    .clock(clock), .reset(reset), .start(start1), .neuron_sel(sel1), .bcast(bcast1),
    .clear(clear1), .in_valid(valid1), .in_ready(ready1), .in_row(row1), .busy(busy1),
    .done(done1), .err(err1), .loaded(loaded1), .kernels(kern1)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic row0_t mk_row0(input logic [7:0] base);
    row0_t r;
    for (int c = 0; c < 4; c++) r[c] = base + 8'(c);
    return r;
  endfunction

  function automatic row1_t mk_row1(input logic [11:0] base);
    row1_t r;
    for (int c = 0; c < 5; c++) r[c] = base + 12'(c);
    return r;
  endfunction

  // Start a load on dut0 and stream nbeats rows (row k base = base + 0x10*k),
  // with optional stall of stall_len cycles before beat stall_at. Returns in
  // the cycle following the last beat.
  task automatic run_load0(input logic [1:0] sel, input logic b, input logic [7:0] base,
                           input int nbeats, input int stall_at, input int stall_len,
                           input string name);
    row0_t r;
    start0 = 1'b1; sel0 = sel; bcast0 = b;
    tick();
    start0 = 1'b0; bcast0 = 1'b0;
    for (int k = 0; k < nbeats; k++) begin
      if (k == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          valid0 = 1'b0; row0 = mk_row0(8'hEE);
          tick();
          checks++; if (ready0 !== 1'b1 || done0 !== 1'b0) begin errors++; $display("FAIL %s_stall%0d: ready=%b done=%b want ready=1 done=0", name, s, ready0, done0); end
        end
      end
      checks++; if (ready0 !== 1'b1 || done0 !== 1'b0) begin errors++; $display("FAIL %s_beat%0d: ready=%b done=%b want ready=1 done=0", name, k, ready0, done0); end
      r = mk_row0(base + 8'(16 * k));
      valid0 = 1'b1; row0 = r;
      tick();
      for (int n = 0; n < 4; n++) if (b || n == int'(sel)) exp0[n][k] = r;
    end
    valid0 = 1'b0; row0 = '0;
  endtask

  task automatic test_reset();
    checks++; if (busy0 !== 1'b0 || ready0 !== 1'b0 || done0 !== 1'b0 || err0 !== 1'b0) begin errors++; $display("FAIL reset_status0: busy=%b ready=%b done=%b err=%b want 0000", busy0, ready0, done0, err0); end
    checks++; if (loaded0 !== 4'b0000 || kern0 !== '0) begin errors++; $display("FAIL reset_store0: loaded=%b kern=%h want 0", loaded0, kern0); end
    checks++; if (busy1 !== 1'b0 || loaded1 !== 3'b000 || kern1 !== '0) begin errors++; $display("FAIL reset_dut1: busy=%b loaded=%b want 0", busy1, loaded1); end
    // reset in the middle of a load, two beats in
    run_load0(2'd0, 1'b0, 8'h10, 2, -1, 0, "rst");
    checks++; if (kern0 !== exp0) begin errors++; $display("FAIL rst_partial: got %h want %h", kern0, exp0); end
    #2 reset = 1'b1;
    #1;
    exp0 = '0;
    checks++; if (kern0 !== exp0 || loaded0 !== 4'b0000 || busy0 !== 1'b0 || ready0 !== 1'b0) begin errors++; $display("FAIL rst_async: kern=%h loaded=%b busy=%b ready=%b want all 0", kern0, loaded0, busy0, ready0); end
    tick();
    reset = 1'b0;
    tick();
    checks++; if (ready0 !== 1'b0 || busy0 !== 1'b0) begin errors++; $display("FAIL rst_release: ready=%b busy=%b want 0 0", ready0, busy0); end
  endtask

  task automatic test_single();
    run_load0(2'd2, 1'b0, 8'h10, 4, -1, 0, "single");
    checks++; if (done0 !== 1'b1) begin errors++; $display("FAIL single_done: got %b want 1", done0); end
    checks++; if (loaded0 !== 4'b0100) begin errors++; $display("FAIL single_loaded: got %b want 0100", loaded0); end
    checks++; if (kern0 !== exp0) begin errors++; $display("FAIL single_data: got %h want %h", kern0, exp0); end
    checks++; if (kern0[2][3] !== 32'h43424140) begin errors++; $display("FAIL single_row3: got %h want 43424140", kern0[2][3]); end
    // start during DONE must be ignored
    start0 = 1'b1; sel0 = 2'd0;
    tick();
    start0 = 1'b0;
    checks++; if (busy0 !== 1'b0 || done0 !== 1'b0 || err0 !== 1'b0 || loaded0 !== 4'b0100) begin errors++; $display("FAIL single_after: busy=%b done=%b err=%b loaded=%b want 0 0 0 0100", busy0, done0, err0, loaded0); end
  endtask

  // back-to-back with the previous load: start issued the first idle cycle
  task automatic test_stall();
    run_load0(2'd3, 1'b0, 8'h30, 4, 2, 3, "stall");
    checks++; if (done0 !== 1'b1) begin errors++; $display("FAIL stall_done: got %b want 1", done0); end
    checks++; if (loaded0 !== 4'b1100) begin errors++; $display("FAIL stall_loaded: got %b want 1100", loaded0); end
    checks++; if (kern0 !== exp0) begin errors++; $display("FAIL stall_data: got %h want %h", kern0, exp0); end
    tick();
    checks++; if (done0 !== 1'b0 || busy0 !== 1'b0) begin errors++; $display("FAIL stall_idle: done=%b busy=%b want 0 0", done0, busy0); end
  endtask

  task automatic test_broadcast();
    run_load0(2'd1, 1'b1, 8'hA0, 4, -1, 0, "bcast");
    checks++; if (done0 !== 1'b1 || loaded0 !== 4'b1111) begin errors++; $display("FAIL bcast_loaded: done=%b loaded=%b want 1 1111", done0, loaded0); end
    checks++; if (kern0 !== exp0) begin errors++; $display("FAIL bcast_data: got %h want %h", kern0, exp0); end
    checks++; if (kern0[0][1] !== 32'hB3B2B1B0) begin errors++; $display("FAIL bcast_slot0: got %h want b3b2b1b0", kern0[0][1]); end
    tick();
  endtask

  task automatic test_abort();
    run_load0(2'd1, 1'b0, 8'h50, 2, -1, 0, "abort");
    checks++; if (loaded0 !== 4'b1101 || ready0 !== 1'b1) begin errors++; $display("FAIL abort_reload: loaded=%b ready=%b want 1101 1", loaded0, ready0); end
    start0 = 1'b1; sel0 = 2'd3;
    tick();
    start0 = 1'b0;
    checks++; if (err0 !== 1'b0 || busy0 !== 1'b1 || loaded0 !== 4'b1101) begin errors++; $display("FAIL abort_ignored_start: err=%b busy=%b loaded=%b want 0 1 1101", err0, busy0, loaded0); end
    clear0 = 1'b1; valid0 = 1'b1; row0 = mk_row0(8'hF0);
    tick();
    clear0 = 1'b0; valid0 = 1'b0;
    checks++; if (busy0 !== 1'b0 || ready0 !== 1'b0 || loaded0 !== 4'b0000) begin errors++; $display("FAIL abort_state: busy=%b ready=%b loaded=%b want 0 0 0000", busy0, ready0, loaded0); end
    checks++; if (kern0 !== exp0) begin errors++; $display("FAIL abort_data: got %h want %h", kern0, exp0); end
    checks++; if (kern0[1][1] !== 32'h63626160 || kern0[1][2] !== 32'hC3C2C1C0) begin errors++; $display("FAIL abort_rows: r1=%h r2=%h want 63626160 c3c2c1c0", kern0[1][1], kern0[1][2]); end
    tick();
    checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL abort_nodone: got %b want 0", done0); end
  endtask

  task automatic test_param_sweep();
    row1_t r;
    start1 = 1'b1; sel1 = 2'd1; bcast1 = 1'b0;
    tick();
    start1 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++; if (ready1 !== 1'b1 || done1 !== 1'b0) begin errors++; $display("FAIL sweep_beat%0d: ready=%b done=%b want 1 0", k, ready1, done1); end
      r = mk_row1(12'(256 * (k + 1)));
      valid1 = 1'b1; row1 = r;
      tick();
      exp1[1][k] = r;
    end
    valid1 = 1'b0;
    checks++; if (done1 !== 1'b1 || loaded1 !== 3'b010) begin errors++; $display("FAIL sweep_done: done=%b loaded=%b want 1 010", done1, loaded1); end
    checks++; if (kern1 !== exp1) begin errors++; $display("FAIL sweep_data: got %h want %h", kern1, exp1); end
    tick();
    checks++; if (done1 !== 1'b0 || busy1 !== 1'b0) begin errors++; $display("FAIL sweep_idle: done=%b busy=%b want 0 0", done1, busy1); end
    // slot 3 does not exist with three slots
    start1 = 1'b1; sel1 = 2'd3;
    tick();
    start1 = 1'b0;
    checks++; if (err1 !== 1'b1 || busy1 !== 1'b0 || ready1 !== 1'b0) begin errors++; $display("FAIL sweep_err: err=%b busy=%b ready=%b want 1 0 0", err1, busy1, ready1); end
    tick();
    checks++; if (err1 !== 1'b0 || loaded1 !== 3'b010) begin errors++; $display("FAIL sweep_err_pulse: err=%b loaded=%b want 0 010", err1, loaded1); end
  endtask

  initial begin
    reset = 1'b1;
    start0 = 1'b0; sel0 = 2'd0; bcast0 = 1'b0; clear0 = 1'b0; valid0 = 1'b0; row0 = '0;
    start1 = 1'b0; sel1 = 2'd0; bcast1 = 1'b0; clear1 = 1'b0; valid1 = 1'b0; row1 = '0;
    exp0 = '0;
    exp1 = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    tick();
    test_reset();
    test_single();
    test_stall();
    test_broadcast();
    test_abort();
    test_param_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
